// File: rtl/alu_pkg.sv
// Shared types and helpers for the EX-stage ALU with RV32M multiply/divide.
package alu_pkg;

    typedef enum logic [4:0] {
        OpAdd    = 5'd0,
        OpSub    = 5'd1,
        OpAnd    = 5'd2,
        OpOr     = 5'd3,
        OpXor    = 5'd4,
        OpSra    = 5'd5,
        OpSrl    = 5'd6,
        OpSll    = 5'd7,
        OpSlt    = 5'd8,
        OpSltu   = 5'd9,
        OpMul    = 5'd16,
        OpMulh   = 5'd17,
        OpMulhsu = 5'd18,
        OpMulhu  = 5'd19,
        OpDiv    = 5'd20,
        OpDivu   = 5'd21,
        OpRem    = 5'd22,
        OpRemu   = 5'd23
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    function automatic logic is_iterative(logic [4:0] op);
        return op[4];
    endfunction

    // Codes 10-15 and 24-31 are unassigned and must behave as single-step ops.
    function automatic logic is_defined(logic [4:0] op);
        return op[4] ? ~op[3] : (op <= 5'd9);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational single-step datapath: shared adder, shared right shifter, logic ops, compares.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);

    localparam int unsigned SHW = $clog2(XLEN);

    logic            sub;
    logic [XLEN:0]   addr;
    logic            lt;
    logic            ltu;
    logic            fill;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] a_rev;
    logic [XLEN-1:0] sh_in;
    logic [XLEN-1:0] sh_out;
    logic [XLEN-1:0] sh_rev;

    always_comb begin
        sub  = (op != OpAdd);
        addr = {1'b0, a} + {1'b0, (sub ? ~b : b)} + (XLEN + 1)'(sub);
        ltu  = ~addr[XLEN];
        // Differing signs decide the compare directly, so overflow of diff is harmless.
        lt   = (a[XLEN-1] ^ b[XLEN-1]) ? a[XLEN-1] : addr[XLEN-1];
    end

    always_comb begin
        for (int i = 0; i < XLEN; i++) begin
            a_rev[i] = a[XLEN-1-i];
        end
        shamt  = b[SHW-1:0];
        fill   = (op == OpSra) & a[XLEN-1];
        sh_in  = (op == OpSll) ? a_rev : a;
        sh_out = XLEN'($signed({fill, sh_in}) >>> shamt);
        for (int i = 0; i < XLEN; i++) begin
            sh_rev[i] = sh_out[XLEN-1-i];
        end
    end

    always_comb begin
        y = '0;
        case (op)
            OpAdd, OpSub: y = addr[XLEN-1:0];
            OpAnd:        y = a & b;
            OpOr:         y = a | b;
            OpXor:        y = a ^ b;
            OpSra, OpSrl: y = sh_out;
            OpSll:        y = sh_rev;
            OpSlt:        y = {{(XLEN-1){1'b0}}, lt};
            OpSltu:       y = {{(XLEN-1){1'b0}}, ltu};
            default:      y = '0;
        endcase
    end

endmodule

// File: rtl/alu_muldiv.sv
// EX-stage ALU with iterative RV32M mul/div behind a valid/ready handshake.
// Define ALU_DIV_EARLY_EN to finish trivial divisions in a single cycle.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    state_e state_q, state_d;

    logic              accept;
    logic              start_iter;
    logic              go_calc;
    logic              in_div;
    logic              sa_in;
    logic              sb_in;
    logic              dz_in;
    logic              early;
    logic [XLEN-1:0]   early_res;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;

    logic [4:0]        op_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic              iter_q;
    logic              div_q;
    logic              rem_q;
    logic              hi_q;
    logic              sa_q;
    logic              sb_q;
    logic              dz_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   mcd_q;
    logic [XLEN-1:0]   md_res_q;

    logic              last;
    logic [XLEN:0]     add_x;
    logic [XLEN:0]     add_y;
    logic              add_ci;
    logic [XLEN+1:0]   add_s;
    logic [2*XLEN-1:0] acc_step;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   fix_res;
    logic [XLEN-1:0]   core_y;

    assign accept     = in_valid & in_ready & ~flush;
    assign start_iter = is_iterative(op) & is_defined(op);
    assign in_div     = start_iter & op[2];
    assign go_calc    = start_iter & ~early;
    assign last       = (cnt_q == CNT_W'(XLEN - 1));

    // DIV/REM treat both operands as signed; MULH both, MULHSU only a.
    always_comb begin
        sa_in = operand_a[XLEN-1] & (in_div ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10));
        sb_in = operand_b[XLEN-1] & (in_div ? ~op[0] : (op[1:0] == 2'b01));
        mag_a = sa_in ? -operand_a : operand_a;
        mag_b = sb_in ? -operand_b : operand_b;
        dz_in = (operand_b == '0);
    end

`ifdef ALU_DIV_EARLY_EN
    logic ovf_in;
    logic ltu_in;

    always_comb begin
        ovf_in = ~op[0] & (operand_a == {1'b1, {(XLEN-1){1'b0}}}) & (&operand_b);
        ltu_in = op[0] & (operand_a < operand_b);
        early  = in_div & (dz_in | ovf_in | ltu_in);
        if (dz_in) begin
            early_res = op[1] ? operand_a : '1;
        end else if (ovf_in) begin
            early_res = op[1] ? '0 : operand_a;
        end else begin
            early_res = op[1] ? operand_a : '0;
        end
    end
`else
    assign early     = 1'b0;
    assign early_res = '0;
`endif

    // One XLEN+1 adder: conditional add for multiply, trial subtract for divide.
    always_comb begin
        if (div_q) begin
            add_x  = acc_q[2*XLEN-1:XLEN-1];
            add_y  = ~{1'b0, mcd_q};
            add_ci = 1'b1;
        end else begin
            add_x  = {1'b0, acc_q[2*XLEN-1:XLEN]};
            add_y  = acc_q[0] ? {1'b0, mcd_q} : '0;
            add_ci = 1'b0;
        end
        add_s = {1'b0, add_x} + {1'b0, add_y} + (XLEN + 2)'(add_ci);
        if (div_q) begin
            acc_step = add_s[XLEN+1] ? {add_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1}
                                     : {acc_q[2*XLEN-2:0], 1'b0};
        end else begin
            acc_step = {add_s[XLEN:0], acc_q[XLEN-1:1]};
        end
    end

    // Sign fix-up applied on the final step so it lands with the CALC->DONE edge.
    always_comb begin
        prod  = (sa_q ^ sb_q) ? -acc_step : acc_step;
        quo_s = (sa_q ^ sb_q) ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
        rem_s = sa_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
        if (div_q) begin
            if (dz_q) begin
                fix_res = rem_q ? a_q : '1;
            end else begin
                fix_res = rem_q ? rem_s : quo_s;
            end
        end else begin
            fix_res = hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            iter_q   <= 1'b0;
            div_q    <= 1'b0;
            rem_q    <= 1'b0;
            hi_q     <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            dz_q     <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcd_q    <= '0;
            md_res_q <= '0;
        end else if (accept) begin
            op_q   <= op;
            a_q    <= operand_a;
            b_q    <= operand_b;
            iter_q <= start_iter;
            div_q  <= in_div;
            rem_q  <= op[1];
            hi_q   <= (op[1:0] != 2'b00);
            sa_q   <= sa_in;
            sb_q   <= sb_in;
            dz_q   <= dz_in;
            cnt_q  <= '0;
            acc_q  <= {{XLEN{1'b0}}, (in_div ? mag_a : mag_b)};
            mcd_q  <= in_div ? mag_b : mag_a;
            if (early) begin
                md_res_q <= early_res;
            end
        end else if (state_q == StCalc) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last) begin
                md_res_q <= fix_res;
            end
        end
    end

    alu_core #(
        .XLEN (XLEN)
    ) u_core (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .y  (core_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = go_calc ? StCalc : StDone;
                end
            end
            StCalc: begin
                if (last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = accept ? (go_calc ? StCalc : StDone) : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (flush) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
        out_valid = (state_q == StDone);
        result    = iter_q ? md_res_q : core_y;
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: arithmetic model plus scoreboard, literal pins and latency checks.
module tb_alu_muldiv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  op = 5'd0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    alu_muldiv #(
        .XLEN (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] ps;
        logic [63:0]        pu;
        logic               ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a & b;
            5'd3:  return a | b;
            5'd4:  return a ^ b;
            5'd5:  return 32'($signed(a) >>> b[4:0]);
            5'd6:  return a >> b[4:0];
            5'd7:  return a << b[4:0];
            5'd8:  return {31'b0, ($signed(a) < $signed(b))};
            5'd9:  return {31'b0, (a < b)};
            5'd16: return a * b;
            5'd17: begin
                ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return ps[63:32];
            end
            5'd18: begin
                ps = $signed({{32{a[31]}}, a}) * $signed({32'b0, b});
                return ps[63:32];
            end
            5'd19: begin
                pu = {32'b0, a} * {32'b0, b};
                return pu[63:32];
            end
            5'd20: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            5'd21: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd22: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            5'd23: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int exp_lat(input logic [4:0] o, input logic [31:0] a,
                                   input logic [31:0] b);
        if (!(o >= 5'd16 && o <= 5'd23)) return 1;
`ifdef ALU_DIV_EARLY_EN
        if (o >= 5'd20) begin
            if (b == 0) return 1;
            if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            if (o[0] && a < b) return 1;
        end
`endif
        return 33;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // Scoreboard compare on every cycle a result is presented.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_out_valid: got result 0x%08h, required no output",
                         result);
            end else begin
                check("scoreboard", result, exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic do_op(input string name, input logic [4:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] lit);
        int w;
        int lat;
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        out_ready = 1'b1;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        exp_q.push_back(model(o, a, b));
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        check({name, "_latency"}, 32'(lat), 32'(exp_lat(o, a, b)));
        check(name, result, lit);
    endtask

    initial begin
        int seen;
        repeat (2) @(negedge clk);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("reset_result", result, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        do_op("add", 5'd0, 32'd3, 32'd4, 32'd7);
        do_op("sub", 5'd1, 32'd5, 32'd7, 32'hFFFF_FFFE);
        do_op("and", 5'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
        do_op("or", 5'd3, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F);
        do_op("xor", 5'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);
        do_op("sll_masked", 5'd7, 32'd1, 32'h0000_0023, 32'd8);
        do_op("srl", 5'd6, 32'h8000_0000, 32'd4, 32'h0800_0000);
        do_op("sra", 5'd5, 32'h8000_0000, 32'd4, 32'hF800_0000);
        do_op("sra_pos31", 5'd5, 32'h7FFF_FFFF, 32'd31, 32'd0);
        do_op("slt_ovf", 5'd8, 32'h8000_0000, 32'h0000_0001, 32'd1);
        do_op("slt_max", 5'd8, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0);
        do_op("sltu", 5'd9, 32'd1, 32'hFFFF_FFFF, 32'd1);
        do_op("undef_10", 5'd10, 32'd9, 32'd9, 32'd0);
        do_op("undef_24", 5'd24, 32'd5, 32'd6, 32'd0);
        do_op("mul", 5'd16, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        do_op("mulh_min", 5'd17, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        do_op("mulh_neg", 5'd17, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
        do_op("mulhsu", 5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("mulhu", 5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        do_op("div", 5'd20, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        do_op("rem", 5'd22, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        do_op("div_negb", 5'd20, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        do_op("rem_negb", 5'd22, 32'd7, 32'hFFFF_FFFE, 32'd1);
        do_op("div_zero", 5'd20, 32'd5, 32'd0, 32'hFFFF_FFFF);
        do_op("rem_zero_neg", 5'd22, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
        do_op("remu_zero", 5'd23, 32'd5, 32'd0, 32'd5);
        do_op("div_ovf", 5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        do_op("rem_ovf", 5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        do_op("divu", 5'd21, 32'd100, 32'd7, 32'd14);
        do_op("remu", 5'd23, 32'd100, 32'd7, 32'd2);
        do_op("divu_small", 5'd21, 32'd3, 32'd10, 32'd0);

        // Reset asserted in the middle of a DIV.
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        op        = 5'd20;
        operand_a = 32'd100;
        operand_b = 32'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_op("add_after_rst", 5'd0, 32'd3, 32'd4, 32'd7);

        // Stall in DONE, then back-to-back accept on the releasing edge.
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        op        = 5'd0;
        operand_a = 32'd5;
        operand_b = 32'd6;
        out_ready = 1'b0;
        @(posedge clk);
        exp_q.push_back(model(5'd0, 32'd5, 32'd6));
        #1;
        in_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_out_valid", {31'b0, out_valid}, 32'd1);
            check("stall_result", result, 32'd11);
            check("stall_in_ready", {31'b0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op        = 5'd4;
        operand_a = 32'hFF00_FF00;
        operand_b = 32'h0F0F_0F0F;
        @(negedge clk);
        check("b2b_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        exp_q.push_back(model(5'd4, 32'hFF00_FF00, 32'h0F0F_0F0F));
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_out_valid", {31'b0, out_valid}, 32'd1);
        check("b2b_xor", result, 32'hF00F_F00F);

        // Flush during MULHU with a coincident request.
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        op        = 5'd19;
        operand_a = 32'h1234_5678;
        operand_b = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        flush     = 1'b1;
        in_valid  = 1'b1;
        op        = 5'd0;
        operand_a = 32'd1;
        operand_b = 32'd2;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_in_ready", {31'b0, in_ready}, 32'd1);
        check("flush_out_valid", {31'b0, out_valid}, 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush_no_result", 32'(seen), 32'd0);

        do_op("mulhu_after_flush", 5'd19, 32'h0001_0000, 32'h0001_0000, 32'd1);
        repeat (2) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no completion, required finish within 500000 time units");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised successor of the combinational execute ALU.
- Adds the RV32M multiply/divide ops alongside the base integer ops, generalised to XLEN.
- Wrapped in a valid/ready handshake so the pipeline can stall on iterative ops.
- Sits in EX stage: decode drives the request side, the EX/MEM register consumes the response side.

Parameters:
- XLEN, 32, operand/result width (>=8, power of 2).
- CNT_W, $clog2(XLEN)+1, iteration counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort of any in-flight op.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept request.
- op  in  5  operation code (alu_pkg::alu_op_e).
- operand_a  in  XLEN  rs1 / dividend / multiplicand.
- operand_b  in  XLEN  rs2 / divisor / multiplier; shift amount = low $clog2(XLEN) bits.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  result value.

Behaviour:
- Reset values: state=IDLE, out_valid=0, result=0, in_ready=1.
- Ops: ADD SUB AND OR XOR SLL SRL SRA SLT SLTU (single-step); MUL MULH MULHSU MULHU DIV DIVU REM REMU (iterative); undefined codes give result 0 with single-step timing.
- Accept: occurs on a clk edge with in_valid && in_ready; operands and op are captured.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- States:
  - IDLE: on accept, single-step ops go to DONE; iterative ops go to CALC with cnt=0.
  - CALC: one step per cycle, cnt++; on cnt==XLEN-1 go to DONE.
  - DONE: out_valid=1 and result held stable until out_ready. When out_ready, return to IDLE, or go directly to DONE/CALC if a new accept happens on the same edge (back-to-back).
- Latency:
  - Single-step ops: out_valid 1 cycle after accept.
  - Iterative ops: out_valid XLEN+1 cycles after accept (XLEN steps plus sign fix-up folded into the CALC->DONE edge).
- SLT: signed compare, correct on overflow: lt = (a[MSB]^b[MSB]) ? a[MSB] : diff[MSB]. SLTU uses the borrow of the XLEN+1-bit subtract.
- SRA: sign-fills; SLL is implemented by bit-reverse around the shared right shifter.
- MUL family:
  - Radix-2 shift-add over operand magnitudes.
  - Signedness per op: MULH s*s, MULHSU s*u, MULHU u*u.
  - The 2*XLEN product is negated when the signs differ.
  - MUL returns product[XLEN-1:0]; the MULH variants return product[2XLEN-1:XLEN].
- DIV family:
  - Restoring division on magnitudes.
  - Quotient sign = sa^sb; remainder sign = sign of dividend.
  - Divide by zero: quotient all-ones, remainder = operand_a.
  - Signed overflow (a = -2^(XLEN-1), b = -1): quotient = a, remainder = 0.
- flush: forces IDLE and out_valid=0 on the next edge and discards any in-flight op. flush has priority over accept and out_ready. An accept coincident with flush is dropped.
- rst_n asserted mid-CALC: immediate return to reset values; no partial result ever appears.
- Stall: in DONE with out_ready=0, result and out_valid hold indefinitely; in_ready=0.

Optional Feature:
- Macro ALU_DIV_EARLY_EN.
- When defined:
  - Divide-by-zero and signed-overflow divisions skip CALC and go IDLE->DONE, so out_valid is 1 cycle after accept.
  - DIVU/REMU with operand_a < operand_b also complete in 1 cycle (quotient 0, remainder a).
- When undefined: every iterative op takes exactly XLEN+1 cycles; the special-case values are unchanged.

Decomposition:
- alu_pkg holds:
  - the alu_op_e enum with 5-bit encoding: ADD=0 SUB=1 AND=2 OR=3 XOR=4 SRA=5 SRL=6 SLL=7 SLT=8 SLTU=9 MUL=16 MULH=17 MULHSU=18 MULHU=19 DIV=20 DIVU=21 REM=22 REMU=23;
  - the state enum (IDLE, CALC, DONE);
  - helper function is_iterative(op) = op[4].
- Sub-module alu_core: the combinational single-step datapath (adder, shifter, logic, compare), parametrised by XLEN and reused by the DONE mux.
- The mul/div iteration stays in the top block, sharing one 2*XLEN shift register and one XLEN+1 adder.

Test Plan:
- Reset mid-CALC of DIV: rst_n low for 1 cycle at cnt=10 -> out_valid=0, in_ready=1; next request ADD 3+4 -> result 7 one cycle after accept.
- SLT overflow: a=0x80000000, b=0x00000001 -> 1. SLT a=0x7FFFFFFF, b=0xFFFFFFFF -> 0. SLTU a=1, b=0xFFFFFFFF -> 1.
- MULH a=0x80000000, b=0x80000000 -> 0x40000000; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF; MUL 7*-3 -> 0xFFFFFFEB. out_valid exactly 33 cycles after accept.
- DIV a=-7, b=2 -> quotient 0xFFFFFFFD; REM -> 0xFFFFFFFF. DIV by 0 -> 0xFFFFFFFF. REM 0x80000000 by -1 -> 0. Timing 33 cycles, or 1 with ALU_DIV_EARLY_EN.
- Back-to-back with stall: ADD accepted, out_ready held low 5 cycles -> result stable and in_ready=0; then out_ready=1 with XOR pending -> XOR accepted on the same edge, its result valid next cycle.
- flush during CALC of MULHU (cnt=5) with a simultaneous in_valid -> no out_valid; request dropped; in_ready=1 next cycle.
